neo_irq_timer: RTL and testbench
================================

Name: neo_irq_timer

Overview:
- Interrupt source and priority encoder that drives the 68000 core's IPL1/IPL0 inputs.
- Holds three pending flags: cold-boot (level 3), programmable raster timer (level 2), vertical blank (level 1).
- The timer is a reloadable down-counter clocked by the 6 MHz pixel enable.
- The 68k programs it through the control/reload/ack register writes decoded upstream (0x3C0006/08/0A/0C).

Parameters:
- TIMER_W, 32, width of reload register and down-counter.
- BOOT_IRQ, 1, when 1 the cold-boot flag is set by reset; when 0 it resets clear.

Ports:
- CLK_24M  input  1  system clock; all state on rising edge.
- nRESET  input  1  asynchronous active-low reset.
- PIX_EN  input  1  6 MHz pixel enable, one CLK_24M cycle wide, every 4th cycle.
- VBL_START  input  1  one-cycle pulse at first vblank line.
- REG_WR  input  1  one-cycle write strobe from 68k bus decode.
- REG_SEL  input  2  0=control, 1=reload high word, 2=reload low word, 3=ack.
- REG_DATA  input  16  write data (word writes only).
- IPL1  output  1  active-low interrupt priority bit 1, to CPU.
- IPL0  output  1  active-low interrupt priority bit 0, to CPU.
- TIMER_CNT  output  TIMER_W  current counter value (debug/verification).

Behaviour:
- Reset values:
  - CTRL=0, RELOAD=0, TIMER_CNT=0.
  - VBL_PEND=0, TMR_PEND=0, BOOT_PEND=BOOT_IRQ.
  - IPL1=1, IPL0=1.
- CTRL register: bits [7:4] of a SEL=0 write.
  - bit4 = timer IRQ enable.
  - bit5 = load counter on low-word write.
  - bit6 = load counter at VBL_START.
  - bit7 = auto-reload on expiry.
  - Other bits are ignored.
- SEL=1 writes RELOAD[31:16]. SEL=2 writes RELOAD[15:0].
  - If CTRL[5] is set, a SEL=2 write also loads the counter: TIMER_CNT <= {RELOAD[31:16], REG_DATA} in the same edge.
- SEL=3 (ack):
  - bit0 clears BOOT_PEND.
  - bit1 clears TMR_PEND.
  - bit2 clears VBL_PEND.
  - Multiple bits may be set in one write.
- VBL_START:
  - Sets VBL_PEND unconditionally.
  - If CTRL[6] is set, loads TIMER_CNT <= RELOAD.
- Counter, evaluated only on PIX_EN cycles:
  - TIMER_CNT==0: hold; no event.
  - TIMER_CNT>1: decrement by 1.
  - TIMER_CNT==1 (expiry): set TMR_PEND if CTRL[4]. Next value is RELOAD if CTRL[7], else 0.
  - Expiry while CTRL[4]=0 still reloads/stops but sets no flag.
- Load priority on the same edge, highest first:
  1. Low-word write load (CTRL[5]).
  2. VBL_START load (CTRL[6]).
  3. Expiry reload/decrement.
  - An expiry on the same edge as a load still sets TMR_PEND (if enabled); the load value wins.
- Flag set vs ack on the same edge: set wins, so the event is not lost.
- Priority encode, registered (IPL changes 1 CLK_24M cycle after a flag change):
  - BOOT_PEND → level 3: IPL1=0, IPL0=0.
  - else TMR_PEND → level 2: IPL1=0, IPL0=1.
  - else VBL_PEND → level 1: IPL1=1, IPL0=0.
  - else IPL1=1, IPL0=1.
- Reset asserted mid-operation returns all state to reset values immediately, regardless of PIX_EN phase.
- TIMER_CNT is an unsigned counter. A RELOAD of 0 with CTRL[7] leaves the counter stopped at 0 after expiry. No wrap below 0.

Test Plan:
- Release nRESET (BOOT_IRQ=1) → IPL1/IPL0 = 1/1 during reset, 0/0 one cycle after release. Ack write SEL=3 data 0x0001 → 1/1 next-next cycle.
- CTRL=0x00B0, RELOAD=0x00000003, low write loads the counter → TIMER_CNT goes 3,2,1 on successive PIX_EN. On the 3rd PIX_EN, TMR_PEND sets and the counter reloads to 3. IPL becomes 0/1; re-fires every 3 PIX_EN until ack 0x0002.
- CTRL=0x0010, RELOAD=2, counter loaded → after expiry, TIMER_CNT holds 0. Only one level-2 event occurs over 20 further PIX_EN.
- VBL_START pulse with TMR_PEND set → IPL stays 0/1. Ack 0x0002 → IPL 1/0 (level 1). Ack 0x0004 → 1/1.
- Same-edge cases:
  - Ack 0x0004 coincident with VBL_START → VBL_PEND remains 1.
  - CTRL[6] set, VBL_START coincident with expiry (RELOAD=5, CTRL=0x00D0) → TIMER_CNT=5 and TMR_PEND=1.
- Assert nRESET mid-count (TIMER_CNT=0x1234, all flags set) → outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/neo_irq_timer.sv
// Interrupt source and priority encoder for the 68000 IPL1/IPL0 inputs.
// It holds three pending flags: cold boot, raster timer and vblank.
module neo_irq_timer #(
    parameter int unsigned TIMER_W  = 32,
    parameter bit          BOOT_IRQ = 1'b1
) (
    input  logic               CLK_24M,
    input  logic               nRESET,
    input  logic               PIX_EN,
    input  logic               VBL_START,
    input  logic               REG_WR,
    input  logic [1:0]         REG_SEL,
    input  logic [15:0]        REG_DATA,
    output logic               IPL1,
    output logic               IPL0,
    output logic [TIMER_W-1:0] TIMER_CNT
);

    // Upper reload word width; TIMER_W must be in the range 17..32.
    localparam int unsigned HI_W = TIMER_W - 16;

    typedef enum logic [1:0] {
        SEL_CTRL      = 2'd0,
        SEL_RELOAD_HI = 2'd1,
        SEL_RELOAD_LO = 2'd2,
        SEL_ACK       = 2'd3
    } reg_sel_e;

    reg_sel_e           sel;
    logic               wr_ctrl, wr_hi, wr_lo, wr_ack;
    logic [2:0]         ack;

    logic               irq_en, load_on_wr, load_on_vbl, auto_reload;
    logic [TIMER_W-1:0] reload, reload_next;
    logic [TIMER_W-1:0] cnt, cnt_next;
    logic               boot_pend, tmr_pend, vbl_pend;
    logic               boot_next, tmr_next, vbl_next;
    logic [1:0]         ipl, ipl_next;
    logic               expire;

    assign sel     = reg_sel_e'(REG_SEL);
    assign wr_ctrl = REG_WR && (sel == SEL_CTRL);
    assign wr_hi   = REG_WR && (sel == SEL_RELOAD_HI);
    assign wr_lo   = REG_WR && (sel == SEL_RELOAD_LO);
    assign wr_ack  = REG_WR && (sel == SEL_ACK);
    assign ack     = wr_ack ? REG_DATA[2:0] : '0;
    assign expire  = PIX_EN && (cnt == TIMER_W'(1));

    always_comb begin
        reload_next = reload;
        if (wr_hi) reload_next[TIMER_W-1:16] = REG_DATA[HI_W-1:0];
        if (wr_lo) reload_next[15:0]         = REG_DATA;
    end

    // Loads override expiry; expiry reload uses the register value before this edge.
    always_comb begin
        cnt_next = cnt;
        if (wr_lo && load_on_wr) begin
            cnt_next = {reload[TIMER_W-1:16], REG_DATA};
        end else if (VBL_START && load_on_vbl) begin
            cnt_next = reload;
        end else if (expire) begin
            cnt_next = auto_reload ? reload : '0;
        end else if (PIX_EN && (cnt != '0)) begin
            cnt_next = cnt - TIMER_W'(1);
        end
    end

    // Setting beats acknowledging so a coincident event is not lost.
    always_comb begin
        boot_next = boot_pend && !ack[0];
        tmr_next  = (expire && irq_en) || (tmr_pend && !ack[1]);
        vbl_next  = VBL_START || (vbl_pend && !ack[2]);
    end

    always_comb begin
        ipl_next = 2'b11;
        if (boot_pend)     ipl_next = 2'b00;
        else if (tmr_pend) ipl_next = 2'b01;
        else if (vbl_pend) ipl_next = 2'b10;
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            irq_en      <= 1'b0;
            load_on_wr  <= 1'b0;
            load_on_vbl <= 1'b0;
            auto_reload <= 1'b0;
            reload      <= '0;
            cnt         <= '0;
            boot_pend   <= BOOT_IRQ;
            tmr_pend    <= 1'b0;
            vbl_pend    <= 1'b0;
            ipl         <= 2'b11;
        end else begin
            if (wr_ctrl) begin
                irq_en      <= REG_DATA[4];
                load_on_wr  <= REG_DATA[5];
                load_on_vbl <= REG_DATA[6];
                auto_reload <= REG_DATA[7];
            end
            reload    <= reload_next;
            cnt       <= cnt_next;
            boot_pend <= boot_next;
            tmr_pend  <= tmr_next;
            vbl_pend  <= vbl_next;
            ipl       <= ipl_next;
        end
    end

    assign IPL1      = ipl[1];
    assign IPL0      = ipl[0];
    assign TIMER_CNT = cnt;

endmodule

// File: tb/tb_neo_irq_timer.sv
// Self-checking bench for neo_irq_timer: directed scenarios plus random
// register traffic, compared against a cycle-level behavioural model.
module tb_neo_irq_timer;

    localparam int unsigned TIMER_W = 32;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               pix_en = 1'b0;
    logic               vbl_start = 1'b0;
    logic               reg_wr = 1'b0;
    logic [1:0]         reg_sel = '0;
    logic [15:0]        reg_data = '0;
    logic               ipl1, ipl0;
    logic [TIMER_W-1:0] timer_cnt;

    int checks = 0;
    int failures = 0;
    int phase = 0;

    // Behavioural model state
    longint unsigned m_cnt, m_reload;
    bit m_en, m_ldwr, m_ldvbl, m_auto;
    bit m_boot, m_tmr, m_vbl;
    int m_level;

    neo_irq_timer #(.TIMER_W(TIMER_W), .BOOT_IRQ(1'b1)) dut (
        .CLK_24M   (clk),
        .nRESET    (rst_n),
        .PIX_EN    (pix_en),
        .VBL_START (vbl_start),
        .REG_WR    (reg_wr),
        .REG_SEL   (reg_sel),
        .REG_DATA  (reg_data),
        .IPL1      (ipl1),
        .IPL0      (ipl0),
        .TIMER_CNT (timer_cnt)
    );

    always #20 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_ipl();
        return 2'(3 - m_level);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_reload = 0;
        m_en = 0; m_ldwr = 0; m_ldvbl = 0; m_auto = 0;
        m_boot = 1; m_tmr = 0; m_vbl = 0;
        m_level = 0;
    endtask

    // One clock edge of the interrupt controller, from the behavioural rules.
    task automatic model_step();
        longint unsigned nc;
        bit expire;
        bit [2:0] ack;
        expire = pix_en && (m_cnt == 1);
        ack = (reg_wr && reg_sel == 2'd3) ? reg_data[2:0] : 3'b000;
        m_level = m_boot ? 3 : m_tmr ? 2 : m_vbl ? 1 : 0;

        nc = m_cnt;
        if (reg_wr && reg_sel == 2'd2 && m_ldwr) nc = (m_reload / 65536) * 65536 + reg_data;
        else if (vbl_start && m_ldvbl)           nc = m_reload;
        else if (expire)                         nc = m_auto ? m_reload : 0;
        else if (pix_en && m_cnt > 0)            nc = m_cnt - 1;

        m_boot = m_boot && !ack[0];
        m_tmr  = (expire && m_en) || (m_tmr && !ack[1]);
        m_vbl  = vbl_start || (m_vbl && !ack[2]);

        if (reg_wr) begin
            case (reg_sel)
                2'd0: begin
                    m_en = reg_data[4]; m_ldwr = reg_data[5];
                    m_ldvbl = reg_data[6]; m_auto = reg_data[7];
                end
                2'd1: m_reload = (m_reload % 65536) + longint'(reg_data) * 65536;
                2'd2: m_reload = (m_reload / 65536) * 65536 + reg_data;
                default: ;
            endcase
        end
        m_cnt = nc;
    endtask

    task automatic cycle(input bit wr, input bit [1:0] sel, input bit [15:0] data, input bit vbl);
        reg_wr = wr; reg_sel = sel; reg_data = data; vbl_start = vbl;
        pix_en = (phase == 3);
        @(posedge clk);
        model_step();
        #1;
        check_val("cnt", 64'(timer_cnt), 64'(m_cnt));
        check_val("ipl", 64'({ipl1, ipl0}), 64'(exp_ipl()));
        phase = (phase + 1) % 4;
        reg_wr = 0; vbl_start = 0; pix_en = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 2'd0, 16'h0, 0);
    endtask

    task automatic wr(input bit [1:0] sel, input bit [15:0] data);
        cycle(1, sel, data, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        model_reset();
        #1;
        check_val("rst_cnt", 64'(timer_cnt), 64'h0);
        check_val("rst_ipl", 64'({ipl1, ipl0}), 64'h3);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        int rises;
        int guard;
        logic [1:0] prev_ipl;
        bit [1:0] rsel;
        bit [15:0] rdata;

        model_reset();
        do_reset();

        // Cold boot: level 3 one cycle after release, cleared by ack bit0.
        idle(1);
        check_val("boot_ipl", 64'({ipl1, ipl0}), 64'h0);
        wr(2'd3, 16'h0001);
        idle(2);
        check_val("boot_ack_ipl", 64'({ipl1, ipl0}), 64'h3);

        // Auto-reloading timer, reload 3.
        wr(2'd0, 16'h00B0);
        wr(2'd1, 16'h0000);
        wr(2'd2, 16'h0003);
        check_val("load3", 64'(timer_cnt), 64'h3);
        idle(48);
        wr(2'd3, 16'h0002);

        // One-shot timer, reload 2: exactly one level-2 event.
        wr(2'd0, 16'h0030);
        wr(2'd2, 16'h0002);
        wr(2'd3, 16'h0002);
        rises = 0;
        prev_ipl = {ipl1, ipl0};
        for (int i = 0; i < 88; i++) begin
            idle(1);
            if ({ipl1, ipl0} == 2'b01 && prev_ipl != 2'b01) rises++;
            prev_ipl = {ipl1, ipl0};
        end
        check_val("oneshot_events", 64'(rises), 64'd1);
        check_val("oneshot_hold0", 64'(timer_cnt), 64'h0);

        // Vblank below a pending timer interrupt.
        cycle(0, 2'd0, 16'h0, 1);
        idle(2);
        check_val("vbl_under_tmr", 64'({ipl1, ipl0}), 64'h1);
        wr(2'd3, 16'h0002);
        idle(2);
        check_val("vbl_level1", 64'({ipl1, ipl0}), 64'h2);
        cycle(1, 2'd3, 16'h0004, 1);
        idle(2);
        check_val("vbl_set_wins", 64'({ipl1, ipl0}), 64'h2);
        wr(2'd3, 16'h0004);
        idle(2);
        check_val("vbl_cleared", 64'({ipl1, ipl0}), 64'h3);

        // VBL load coincident with expiry: load wins, flag still sets.
        wr(2'd0, 16'h00D0);
        wr(2'd1, 16'h0000);
        wr(2'd2, 16'h0005);
        cycle(0, 2'd0, 16'h0, 1);
        guard = 0;
        while (!(timer_cnt == 1 && phase == 3) && guard < 64) begin
            idle(1);
            guard++;
        end
        if (guard >= 64) check_val("wait_expiry", 64'h0, 64'h1);
        cycle(0, 2'd0, 16'h0, 1);
        check_val("vbl_exp_cnt", 64'(timer_cnt), 64'h5);
        idle(1);
        check_val("vbl_exp_tmr", 64'({ipl1, ipl0}), 64'h1);
        wr(2'd3, 16'h0007);
        idle(2);

        // Random register traffic with small reload values to provoke expiries.
        for (int i = 0; i < 3000; i++) begin
            rsel = 2'($urandom_range(0, 3));
            rdata = 16'($urandom);
            if (rsel == 2'd2) rdata = 16'($urandom_range(0, 20));
            if (rsel == 2'd1 && ($urandom % 8) != 0) rdata = 16'h0;
            cycle(($urandom % 6) == 0, rsel, rdata, ($urandom % 50) == 0);
        end

        // Asynchronous reset mid-count.
        wr(2'd0, 16'h0030);
        wr(2'd1, 16'h0000);
        wr(2'd2, 16'h1234);
        cycle(0, 2'd0, 16'h0, 1);
        idle(3);
        #5;
        rst_n = 0;
        #1;
        check_val("async_cnt", 64'(timer_cnt), 64'h0);
        check_val("async_ipl", 64'({ipl1, ipl0}), 64'h3);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
